// File: rtl/alu_sequencer.sv
// Sequencer that feeds an external combinational ALU from a 16 x N register file.
// Fixed 4-cycle instruction (accept, READ, EXEC, WB); instr_ready only in IDLE, nothing is buffered.
module alu_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  input  logic [31:0]  instr_data,
  output logic         instr_ready,
  output logic [3:0]   alu_opcode,
  output logic [N-1:0] alu_operand_a,
  output logic [N-1:0] alu_operand_b,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carryout,
  output logic         wb_valid,
  output logic [3:0]   wb_addr,
  output logic [N-1:0] wb_data,
  output logic         carry_flag,
  output logic         illegal,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    instr_q, instr_d;
  logic [3:0]     alu_opcode_q, alu_opcode_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic           wb_valid_q, wb_valid_d;
  logic [3:0]     wb_addr_q, wb_addr_d;
  logic [N-1:0]   wb_data_q, wb_data_d;
  logic           carry_q, carry_d;
  logic           illegal_q, illegal_d;
  logic           ready_q, ready_d;
  logic           busy_q, busy_d;
  logic [N-1:0]   rf_q [16];
  logic [N-1:0]   rf_d [16];

  logic [3:0]     dec_op;
  logic [3:0]     dec_rd;
  logic [3:0]     dec_rs1;
  logic [3:0]     dec_rs2;
  logic           dec_use_imm;
  logic [14:0]    dec_imm;
  logic           dec_illegal;

  assign dec_op      = instr_q[31:28];
  assign dec_rd      = instr_q[27:24];
  assign dec_rs1     = instr_q[23:20];
  assign dec_rs2     = instr_q[19:16];
  assign dec_use_imm = instr_q[15];
  assign dec_imm     = instr_q[14:0];
  // Opcodes 1010..1111 are unsupported.
  assign dec_illegal = dec_op[3] & (dec_op[2] | dec_op[1]);

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    alu_opcode_d = alu_opcode_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    wb_valid_d   = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    carry_d      = carry_q;
    illegal_d    = 1'b0;
    ready_d      = ready_q;
    busy_d       = busy_q;
    rf_d         = rf_q;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr_data;
          state_d = READ;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      READ: begin
        if (dec_illegal) begin
          state_d   = IDLE;
          illegal_d = 1'b1;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          alu_opcode_d = dec_op;
          opa_d        = rf_q[dec_rs1];
          opb_d        = dec_use_imm ? N'(dec_imm) : rf_q[dec_rs2];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        wb_data_d  = alu_result;
        wb_addr_d  = dec_rd;
        wb_valid_d = 1'b1;
        if (dec_op == 4'd0) begin
          carry_d = alu_carryout;
        end
        state_d = WB;
      end
      WB: begin
        // r0 is never written so it keeps its reset value of zero.
        if (dec_rd != 4'd0) begin
          rf_d[dec_rd] = wb_data_q;
        end
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      alu_opcode_q <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      carry_q      <= 1'b0;
      illegal_q    <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      alu_opcode_q <= alu_opcode_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      carry_q      <= carry_d;
      illegal_q    <= illegal_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign instr_ready   = ready_q;
  assign busy          = busy_q;
  assign alu_opcode    = alu_opcode_q;
  assign alu_operand_a = opa_q;
  assign alu_operand_b = opb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign carry_flag    = carry_q;
  assign illegal       = illegal_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, giving the datapath and register width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port instr_valid  input  1  an instruction word is offered.
REQ-005 SHALL have port instr_data  input  32  instruction word: [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15] use_imm, [14:0] imm.
REQ-006 SHALL have port instr_ready  output  1  the sequencer accepts instr_data this cycle.
REQ-007 SHALL have port alu_opcode  output  4  operation code driven to the ALU.
REQ-008 SHALL have port alu_operand_a  output  N  ALU operand A.
REQ-009 SHALL have port alu_operand_b  output  N  ALU operand B.
REQ-010 SHALL have port alu_result  input  N  combinational ALU result.
REQ-011 SHALL have port alu_carryout  input  1  ALU carry out; meaningful for add only.
REQ-012 SHALL have port wb_valid  output  1  one-cycle writeback strobe.
REQ-013 SHALL have port wb_addr  output  4  writeback register index.
REQ-014 SHALL have port wb_data  output  N  writeback value.
REQ-015 SHALL have port carry_flag  output  1  carry from the last completed add.
REQ-016 SHALL have port illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-017 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 SHALL contain a 16 x N register file; r0 reads as 0 and writes to r0 are discarded, although wb_valid still pulses for an rd=0 instruction.
REQ-019 SHALL use an FSM with states IDLE, READ, EXEC and WB; instr_ready = 1 only in IDLE.
REQ-020 SHALL accept an instruction on a rising edge where instr_valid & instr_ready; the word is latched and the state moves IDLE->READ.
REQ-021 SHALL, on leaving READ, latch the operands: opA = rf[rs1]; opB = {zeros, imm} when use_imm = 1, else rf[rs2]; then READ->EXEC.
REQ-022 SHALL, in EXEC, drive alu_opcode, alu_operand_a and alu_operand_b from the latched values.
REQ-023 SHALL, on the edge leaving EXEC, sample alu_result into wb_data and move EXEC->WB; carry_flag is updated with alu_carryout only if opcode = 0000, otherwise it holds.
REQ-024 SHALL, in WB, assert wb_valid for exactly one cycle with wb_addr = rd; rf[rd] is written on the edge leaving WB, then WB->IDLE.
REQ-025 SHALL, with acceptance at edge 0, have wb_valid high in cycle 3 and instr_ready high again in cycle 4, giving a throughput of 1 instruction per 4 cycles.
REQ-026 SHALL ensure an instruction accepted in cycle 4 reads the value written by the previous instruction; no bypass is required.
REQ-027 SHALL treat opcodes 1010-1111 as illegal: READ->IDLE, illegal pulses for one cycle in the following cycle, with no EXEC, no writeback and no carry update.
REQ-028 SHALL keep alu_opcode and both operands at their last latched values outside EXEC.
REQ-029 SHALL ignore instr_valid while busy; instr_data SHALL NOT be sampled then.

Reset
REQ-030 SHALL, while rst = 1, force state IDLE, all rf entries 0, and instr_ready = 1; every other output SHALL be 0.
REQ-031 SHALL, on an rst assertion mid-instruction, abort the instruction with no writeback and no carry update; operation resumes from IDLE on the first edge after deassertion.

Verification
REQ-032 SHALL verify: ADD r1 = r0 + imm 5 (0x0_1_0_0_8005) -> wb_valid in cycle 3, wb_addr = 1, wb_data = 5, carry_flag = 0.
REQ-033 SHALL verify: with r1 = 5 and r2 = 3, SUB r3 = r1 - r2 -> alu_opcode = 0001 in EXEC, wb_data = 2.
REQ-034 SHALL verify: r1 = 0xFFFFFFFF followed by ADD r4 = r1 + imm 1 -> wb_data = 0 and carry_flag = 1; a following AND leaves carry_flag = 1.
REQ-035 SHALL verify: opcode 1100 -> illegal pulses once, wb_valid stays 0, and instr_ready returns after 2 cycles.
REQ-036 SHALL verify: ADD with rd = 0 and imm 7, then reading r0 -> wb_valid pulses but r0 stays 0.
REQ-037 SHALL verify: rst asserted in EXEC -> no wb_valid, carry_flag = 0, rf cleared, and instr_ready = 1 after release.
